enemy_formation_ctrl: RTL and testbench

Parametrised controller for the invader formation: a ROWS x COLS grid that marches horizontally, descends and reverses at the screen edges, and speeds up as enemies die. Owns the alive bitmap, the formation origin, the win/lose flags and enemy shooter selection. Sits between the per-enemy sprite/collision instances (kill reports in, origin and alive out) and the game engine (start, cleared, invaded).

---
 rtl/formation_pkg.sv | 28 ++
 rtl/formation_extent.sv | 67 ++++++
 rtl/enemy_formation_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_enemy_formation_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/formation_pkg.sv
// Shared definitions for the invader formation controller.
//   state_e   : controller state (IDLE / MARCH / DONE)
//   COORD_W   : width of all screen coordinates and position arithmetic
//   SCREEN_*  : default playfield limits
//   idx_w()   : bits needed to index n items (at least 1)
//   cnt_w()   : bits needed to count 0..n
package formation_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARCH = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int COORD_W      = 11;
  localparam int SCREEN_L_DEF = 0;
  localparam int SCREEN_R_DEF = 640;
  localparam int BOTTOM_Y_DEF = 400;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/formation_extent.sv
// Combinational extent of the alive bitmap.
//   alive   : in  ROWS*COLS bitmap, bit index = row*COLS + col
//   lc / rc : out leftmost / rightmost column holding a live enemy
//   br      : out bottom-most row holding a live enemy
//   count   : out number of live enemies
//   col_has : out per-column "any enemy alive"
//   col_row : out per-column highest alive row (packed, col c at c*RW)
// Outputs are 0 when nothing is alive; callers qualify with count/col_has.
module formation_extent
  import formation_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 8
) (
  input  logic [ROWS*COLS-1:0]          alive,
  output logic [idx_w(COLS)-1:0]        lc,
  output logic [idx_w(COLS)-1:0]        rc,
  output logic [idx_w(ROWS)-1:0]        br,
  output logic [cnt_w(ROWS*COLS)-1:0]   count,
  output logic [COLS-1:0]               col_has,
  output logic [COLS*idx_w(ROWS)-1:0]   col_row
);

  localparam int N  = ROWS * COLS;
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam int AW = cnt_w(N);

  logic [ROWS-1:0] row_has;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign row_has[gi] = |alive[gi*COLS +: COLS];
  end

  // Rows are scanned upward so the last hit in a column is its lowest
  // on-screen (highest-numbered) live enemy.
  always_comb begin
    count   = '0;
    col_has = '0;
    col_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive[r*COLS + c]) begin
          count               = count + AW'(1);
          col_has[c]          = 1'b1;
          col_row[c*RW +: RW] = RW'(r);
        end
      end
    end
  end

  always_comb begin
    lc = '0;
    rc = '0;
    br = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_has[c]) lc = CW'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (col_has[c]) rc = CW'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (row_has[r]) br = RW'(r);
    end
  end

endmodule

// File: rtl/enemy_formation_ctrl.sv
// Invader formation controller: marches a ROWS x COLS grid sideways,
// descends and reverses at the screen edges, speeds up as enemies die,
// tracks the alive bitmap, reports wave cleared / invaded and picks the
// enemy that fires for a requested column.
//   clk, reset       : clock, synchronous active-high reset
//   start            : begin / restart a wave (ignored while marching)
//   kill_valid/_idx  : enemy kill report, idx = row*COLS + col
//   shoot_req/_col   : shooter request for one column
//   alive            : alive bitmap
//   origin_x/_y      : formation top-left corner
//   direction        : 0 = moving right, 1 = moving left
//   step_pulse       : high in the cycle a move/descent is taken
//   alive_count      : number of live enemies
//   cleared/invaded  : wave won / formation reached the invasion line
//   shoot_ack        : one cycle after shoot_req
//   shooter_valid/idx: lowest live enemy in the requested column
module enemy_formation_ctrl
  import formation_pkg::*;
#(
  parameter int ROWS     = 3,
  parameter int COLS     = 8,
  parameter int X0       = 150,
  parameter int Y0       = 40,
  parameter int DX       = 60,
  parameter int DY       = 50,
  parameter int ENEMY_W  = 40,
  parameter int ENEMY_H  = 30,
  parameter int STEP_X   = 20,
  parameter int STEP_Y   = 25,
  parameter int SCREEN_L = SCREEN_L_DEF,
  parameter int SCREEN_R = SCREEN_R_DEF,
  parameter int BOTTOM_Y = BOTTOM_Y_DEF,
  parameter int TICK_MIN = 2000000,
  parameter int TICK_PER = 500000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             kill_valid,
  input  logic [idx_w(ROWS*COLS)-1:0]      kill_idx,
  input  logic                             shoot_req,
  input  logic [idx_w(COLS)-1:0]           shoot_col,
  output logic [ROWS*COLS-1:0]             alive,
  output logic [COORD_W-1:0]               origin_x,
  output logic [COORD_W-1:0]               origin_y,
  output logic                             direction,
  output logic                             step_pulse,
  output logic [cnt_w(ROWS*COLS)-1:0]      alive_count,
  output logic                             cleared,
  output logic                             invaded,
  output logic                             shoot_ack,
  output logic                             shooter_valid,
  output logic [idx_w(ROWS*COLS)-1:0]      shooter_idx
);

  localparam int N  = ROWS * COLS;
  localparam int IW = idx_w(N);
  localparam int CW = idx_w(COLS);
  localparam int RW = idx_w(ROWS);
  localparam int AW = cnt_w(N);
  localparam int TW = cnt_w(TICK_MIN + N * TICK_PER);

  localparam logic [COORD_W-1:0] X0_C  = COORD_W'(X0);
  localparam logic [COORD_W-1:0] Y0_C  = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] DX_C  = COORD_W'(DX);
  localparam logic [COORD_W-1:0] DY_C  = COORD_W'(DY);
  localparam logic [COORD_W-1:0] W_C   = COORD_W'(ENEMY_W);
  localparam logic [COORD_W-1:0] H_C   = COORD_W'(ENEMY_H);
  localparam logic [COORD_W-1:0] SX_C  = COORD_W'(STEP_X);
  localparam logic [COORD_W-1:0] SY_C  = COORD_W'(STEP_Y);
  localparam logic [COORD_W-1:0] SL_C  = COORD_W'(SCREEN_L);
  localparam logic [COORD_W-1:0] SR_C  = COORD_W'(SCREEN_R);
  localparam logic [COORD_W-1:0] BOT_C = COORD_W'(BOTTOM_Y);

  // The starting formation must fit on screen.
  if (X0 + (COLS - 1) * DX + ENEMY_W > SCREEN_R) begin : g_bad_geometry
    $error("formation does not fit: X0+(COLS-1)*DX+ENEMY_W exceeds SCREEN_R");
  end

  state_e             state_q, state_d;
  logic [N-1:0]       alive_q, alive_d;
  logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic               dir_q, dir_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic               cleared_q, cleared_d, invaded_q, invaded_d;
  logic               ack_q, ack_d, req_ok_q, req_ok_d;
  logic [CW-1:0]      col_q, col_d;

  logic [CW-1:0]      lc, rc;
  logic [RW-1:0]      br;
  logic [AW-1:0]      alive_cnt;
  logic [COLS-1:0]    col_has;
  logic [COLS*RW-1:0] col_row;

  logic [N-1:0]       kill_mask;
  logic [TW-1:0]      period;
  logic [COORD_W-1:0] right_edge, left_edge, bottom_edge;
  logic               tick;
  logic               sel_has;
  logic [RW-1:0]      sel_row;

  formation_extent #(.ROWS(ROWS), .COLS(COLS)) u_extent (
    .alive   (alive_q),
    .lc      (lc),
    .rc      (rc),
    .br      (br),
    .count   (alive_cnt),
    .col_has (col_has),
    .col_row (col_row)
  );

  // Out-of-range indices match no bit; already-dead bits stay dead.
  always_comb begin
    kill_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (kill_valid && (kill_idx == IW'(i))) kill_mask[i] = 1'b1;
    end
  end

  // Left test is written as a sum so the unsigned compare never wraps.
  always_comb begin
    period      = TW'(TICK_MIN) + TW'(alive_cnt) * TW'(TICK_PER);
    right_edge  = ox_q + SX_C + COORD_W'(rc) * DX_C + W_C;
    left_edge   = ox_q + COORD_W'(lc) * DX_C;
    bottom_edge = oy_q + COORD_W'(br) * DY_C + H_C;
  end

  always_comb begin
    state_d   = state_q;
    alive_d   = alive_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    cleared_d = cleared_q;
    invaded_d = invaded_q;
    ack_d     = shoot_req;
    col_d     = shoot_req ? shoot_col : col_q;
    req_ok_d  = shoot_req && (state_q == MARCH);
    tick      = 1'b0;
    case (state_q)
      MARCH: begin
        cnt_d   = cnt_q + TW'(1);
        alive_d = alive_q & ~kill_mask;
        if (alive_cnt == '0) begin
          state_d   = DONE;
          cleared_d = 1'b1;
        end else if (bottom_edge >= BOT_C) begin
          state_d   = DONE;
          invaded_d = 1'b1;
        end else if (cnt_q >= period - TW'(1)) begin
          // ">=" keeps ticking correctly when kills shrink the period mid-count.
          tick  = 1'b1;
          cnt_d = '0;
          if ((!dir_q && (right_edge > SR_C)) || (dir_q && (left_edge < SL_C + SX_C))) begin
            oy_d  = oy_q + SY_C;
            dir_d = ~dir_q;
          end else if (!dir_q) begin
            ox_d = ox_q + SX_C;
          end else begin
            ox_d = ox_q - SX_C;
          end
        end
      end
      default: begin
        if (start) begin
          state_d   = MARCH;
          alive_d   = '1;
          ox_d      = X0_C;
          oy_d      = Y0_C;
          dir_d     = 1'b0;
          cnt_d     = '0;
          cleared_d = 1'b0;
          invaded_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      alive_q   <= '1;
      ox_q      <= X0_C;
      oy_q      <= Y0_C;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      cleared_q <= 1'b0;
      invaded_q <= 1'b0;
      ack_q     <= 1'b0;
      req_ok_q  <= 1'b0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      cleared_q <= cleared_d;
      invaded_q <= invaded_d;
      ack_q     <= ack_d;
      req_ok_q  <= req_ok_d;
      col_q     <= col_d;
    end
  end

  always_comb begin
    sel_has = 1'b0;
    sel_row = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_q == CW'(c)) begin
        sel_has = col_has[c];
        sel_row = col_row[c*RW +: RW];
      end
    end
  end

  assign shooter_valid = ack_q & req_ok_q & sel_has;
  assign shooter_idx   = shooter_valid ? (IW'(sel_row) * IW'(COLS) + IW'(col_q)) : '0;
  assign shoot_ack     = ack_q;
  assign alive         = alive_q;
  assign origin_x      = ox_q;
  assign origin_y      = oy_q;
  assign direction     = dir_q;
  assign step_pulse    = tick;
  assign alive_count   = alive_cnt;
  assign cleared       = cleared_q;
  assign invaded       = invaded_q;

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Directed bench for enemy_formation_ctrl with a short tick period
// (TICK_MIN=4, TICK_PER=1 -> 28 cycles per step with all 24 alive).
module tb_enemy_formation_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        kill_valid = 1'b0;
  logic [4:0]  kill_idx = '0;
  logic        shoot_req = 1'b0;
  logic [2:0]  shoot_col = '0;
  logic [23:0] alive;
  logic [10:0] origin_x, origin_y;
  logic        direction, step_pulse, cleared, invaded;
  logic [4:0]  alive_count;
  logic        shoot_ack, shooter_valid;
  logic [4:0]  shooter_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  enemy_formation_ctrl #(.TICK_MIN(4), .TICK_PER(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .kill_valid    (kill_valid),
    .kill_idx      (kill_idx),
    .shoot_req     (shoot_req),
    .shoot_col     (shoot_col),
    .alive         (alive),
    .origin_x      (origin_x),
    .origin_y      (origin_y),
    .direction     (direction),
    .step_pulse    (step_pulse),
    .alive_count   (alive_count),
    .cleared       (cleared),
    .invaded       (invaded),
    .shoot_ack     (shoot_ack),
    .shooter_valid (shooter_valid),
    .shooter_idx   (shooter_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic kill(input int idx);
    kill_valid = 1'b1;
    kill_idx   = 5'(idx);
    step();
    kill_valid = 1'b0;
    $display("kill idx=%0d -> alive_count=%0d", idx, alive_count);
  endtask

  // Leaves the bench in the acknowledge cycle.
  task automatic shoot(input int col);
    shoot_req = 1'b1;
    shoot_col = 3'(col);
    step();
    shoot_req = 1'b0;
    $display("shoot col=%0d -> ack=%0b valid=%0b idx=%0d", col, shoot_ack, shooter_valid, shooter_idx);
  endtask

  // Returns in the tick cycle; n = 1 means the current cycle was the tick.
  task automatic wait_tick(output int n);
    n = 1;
    while (step_pulse !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (step_pulse !== 1'b1) chk("tick_timeout", 32'(step_pulse), 1);
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_alive"}, 32'(alive), 32'h00FF_FFFF);
    chk({pfx, "_ox"}, 32'(origin_x), 150);
    chk({pfx, "_oy"}, 32'(origin_y), 40);
    chk({pfx, "_dir"}, 32'(direction), 0);
    chk({pfx, "_step"}, 32'(step_pulse), 0);
    chk({pfx, "_count"}, 32'(alive_count), 24);
    chk({pfx, "_cleared"}, 32'(cleared), 0);
    chk({pfx, "_invaded"}, 32'(invaded), 0);
    chk({pfx, "_ack"}, 32'(shoot_ack), 0);
    chk({pfx, "_svalid"}, 32'(shooter_valid), 0);
    chk({pfx, "_sidx"}, 32'(shooter_idx), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    @(negedge clk);

    // 1: reset values, first tick latency, move then descend
    do_reset();
    check_reset("t1_rst");
    do_start();
    wait_tick(n);
    $display("tick after %0d cycles", n);
    chk("t1_lat", 32'(n), 28);
    step();
    chk("t1_x1", 32'(origin_x), 170);
    chk("t1_y1", 32'(origin_y), 40);
    chk("t1_step_low", 32'(step_pulse), 0);
    wait_tick(n);
    chk("t1_lat2", 32'(n), 28);
    step();
    chk("t1_x2", 32'(origin_x), 170);
    chk("t1_y2", 32'(origin_y), 65);
    chk("t1_dir2", 32'(direction), 1);

    // 2: column 7 dead -> narrower formation marches further right, period 25
    do_reset();
    do_start();
    kill(7);
    kill(15);
    kill(23);
    chk("t2_count", 32'(alive_count), 21);
    wait_tick(n);
    step();
    chk("t2_x0", 32'(origin_x), 170);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(n);
      chk("t2_lat", 32'(n), 25);
      step();
      chk("t2_x", 32'(origin_x), 32'(170 + 20 * k));
    end
    wait_tick(n);
    chk("t2_lat_d", 32'(n), 25);
    step();
    chk("t2_desc_x", 32'(origin_x), 230);
    chk("t2_desc_y", 32'(origin_y), 65);
    chk("t2_desc_dir", 32'(direction), 1);

    // 3: kill everything (with a duplicate) -> cleared
    do_reset();
    do_start();
    for (int i = 0; i < 24; i++) begin
      kill(i);
      if (i == 3) begin
        kill(3);
        chk("t3_dup", 32'(alive_count), 20);
      end
    end
    chk("t3_count0", 32'(alive_count), 0);
    chk("t3_cleared_pre", 32'(cleared), 0);
    step();
    chk("t3_cleared", 32'(cleared), 1);
    chk("t3_invaded", 32'(invaded), 0);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (step_pulse === 1'b1) pulses++;
      step();
    end
    chk("t3_no_steps", 32'(pulses), 0);
    chk("t3_count_end", 32'(alive_count), 0);

    // 4: march to the invasion line, freeze, restart
    do_reset();
    do_start();
    n = 0;
    while (invaded !== 1'b1 && n < 4000) begin
      step();
      n++;
    end
    chk("t4_invaded", 32'(invaded), 1);
    chk("t4_cleared", 32'(cleared), 0);
    chk("t4_oy", 32'(origin_y), 290);
    chk("t4_ox", 32'(origin_x), 10);
    chk("t4_dir", 32'(direction), 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (step_pulse === 1'b1) pulses++;
      step();
    end
    chk("t4_no_steps", 32'(pulses), 0);
    chk("t4_frozen_oy", 32'(origin_y), 290);
    chk("t4_frozen_ox", 32'(origin_x), 10);
    do_start();
    chk("t4_re_ox", 32'(origin_x), 150);
    chk("t4_re_oy", 32'(origin_y), 40);
    chk("t4_re_alive", 32'(alive), 32'h00FF_FFFF);
    chk("t4_re_invaded", 32'(invaded), 0);
    chk("t4_re_cleared", 32'(cleared), 0);

    // 5: shooter selection
    do_reset();
    shoot(0);
    chk("t5_idle_ack", 32'(shoot_ack), 1);
    chk("t5_idle_valid", 32'(shooter_valid), 0);
    step();
    chk("t5_ack_low", 32'(shoot_ack), 0);
    do_start();
    kill(20);
    kill(12);
    shoot(4);
    chk("t5_ack", 32'(shoot_ack), 1);
    chk("t5_valid", 32'(shooter_valid), 1);
    chk("t5_idx", 32'(shooter_idx), 4);
    shoot(7);
    chk("t5_idx7", 32'(shooter_idx), 23);
    kill(4);
    shoot(4);
    chk("t5_empty_ack", 32'(shoot_ack), 1);
    chk("t5_empty_valid", 32'(shooter_valid), 0);
    chk("t5_empty_idx", 32'(shooter_idx), 0);

    // 6: kill on a tick uses pre-kill extent; reset mid-march
    do_reset();
    do_start();
    kill(15);
    kill(23);
    wait_tick(n);
    step();
    chk("t6_x1", 32'(origin_x), 170);
    wait_tick(n);
    kill_valid = 1'b1;
    kill_idx   = 5'd7;
    step();
    kill_valid = 1'b0;
    chk("t6_desc_y", 32'(origin_y), 65);
    chk("t6_desc_x", 32'(origin_x), 170);
    chk("t6_dir", 32'(direction), 1);
    chk("t6_alive", 32'(alive), 32'h007F_7F7F);
    chk("t6_count", 32'(alive_count), 21);
    for (int i = 0; i < 10; i++) step();
    reset      = 1'b1;
    kill_valid = 1'b1;
    kill_idx   = 5'd0;
    step();
    reset      = 1'b0;
    kill_valid = 1'b0;
    check_reset("t6_rst");
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (step_pulse === 1'b1) pulses++;
      step();
    end
    chk("t6_idle_steps", 32'(pulses), 0);
    chk("t6_idle_ox", 32'(origin_x), 150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
